// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator with decode-stage redirect.
// Selects between sequential fetch, branch target and jump target, and
// raises pc_bj when the decode stage redirects the front end.
// Optional return-address stack enabled by defining PC_GEN_RAS_EN; it adds
// the ras_empty / ras_full outputs.
module pc_gen #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            id_valid,
  input  logic [2:0]      Branch,
  input  logic [1:0]      Jump,
  input  logic            Equal,
  input  logic            rs_sign,
  input  logic            rs_zero,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_branch,
  input  logic [25:0]     in_j,
  input  logic [XLEN-1:0] in_jr,
  input  logic            is_ret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] next_pc,
  output logic            pc_bj
`ifdef PC_GEN_RAS_EN
  ,
  output logic            ras_empty,
  output logic            ras_full
`endif
);

  typedef enum logic [1:0] {
    JMP_NONE = 2'b00,
    JMP_JR   = 2'b01,
    JMP_JAL  = 2'b10,
    JMP_J    = 2'b11
  } jump_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BLEZ = 3'b011,
    BR_BGTZ = 3'b100,
    BR_BLTZ = 3'b101,
    BR_BGEZ = 3'b110,
    BR_RSVD = 3'b111
  } branch_e;

  jump_e           jump_op;
  branch_e         branch_op;
  logic            act;
  logic            taken;
  logic            is_jump;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] j_target;
  logic [XLEN-1:0] jr_target;
  logic [XLEN-1:0] sel_target;

  assign jump_op   = jump_e'(Jump);
  assign branch_op = branch_e'(Branch);

  // Decode-stage actions are only honoured for a valid, non-stalled slot.
  assign act       = id_valid & ~stall;
  assign is_jump   = (jump_op != JMP_NONE);

  assign seq_pc    = pc + XLEN'(1);
  assign br_target = in_pc + in_branch + XLEN'(1);
  assign j_target  = {in_pc[XLEN-1:26], in_j};

  // Branch condition evaluation from the decode-stage comparator results.
  always_comb begin
    taken = 1'b0;
    unique case (branch_op)
      BR_BEQ:  taken = Equal;
      BR_BNE:  taken = ~Equal;
      BR_BLEZ: taken = rs_sign | rs_zero;
      BR_BGTZ: taken = ~rs_sign & ~rs_zero;
      BR_BLTZ: taken = rs_sign;
      BR_BGEZ: taken = ~rs_sign;
      default: taken = 1'b0;
    endcase
  end

`ifdef PC_GEN_RAS_EN
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [PTR_W-1:0] ras_top_idx;
  logic [CNT_W-1:0] ras_cnt;
  logic             ras_push;
  logic             ras_pop;
  logic             ras_hit;

  assign ras_push    = act & (jump_op == JMP_JAL);
  assign ras_pop     = act & (jump_op == JMP_JR) & is_ret;
  assign ras_top_idx = ras_ptr - PTR_W'(1);
  assign ras_hit     = ras_pop & (ras_cnt != '0);
  assign jr_target   = ras_hit ? ras_mem[ras_top_idx] : in_jr;
  assign ras_empty   = (ras_cnt == '0);
  assign ras_full    = (ras_cnt == CNT_W'(RAS_DEPTH));

  // Return-address storage; ras_ptr is the next free slot, so a push when
  // full lands on the oldest entry because the pointer wraps modulo depth.
  always_ff @(posedge clk) begin
    if (ras_push) begin
      ras_mem[ras_ptr] <= in_pc + XLEN'(1);
    end
  end

  // Stack pointer and occupancy; count saturates on overflow, floors at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (ras_push) begin
      ras_ptr <= ras_ptr + PTR_W'(1);
      if (ras_cnt != CNT_W'(RAS_DEPTH)) begin
        ras_cnt <= ras_cnt + CNT_W'(1);
      end
    end else if (ras_hit) begin
      ras_ptr <= ras_top_idx;
      ras_cnt <= ras_cnt - CNT_W'(1);
    end
  end
`else
  logic unused_is_ret;

  assign unused_is_ret = is_ret;
  assign jr_target     = in_jr;
`endif

  // Redirect target select; any jump outranks a branch.
  always_comb begin
    sel_target = br_target;
    if (is_jump) begin
      sel_target = (jump_op == JMP_JR) ? jr_target : j_target;
    end
  end

  assign pc_bj = act & (is_jump | taken);

  // Next fetch address: hold on stall, redirect on pc_bj, else sequential.
  always_comb begin
    next_pc = seq_pc;
    if (stall) begin
      next_pc = pc;
    end else if (pc_bj) begin
      next_pc = sel_target;
    end
  end

  // Fetch PC register; asynchronous reset drops any pending redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= next_pc;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table, reset sequences,
// randomized stimulus against a behavioural model, and (with PC_GEN_RAS_EN)
// the return-address-stack sequence.
module tb_pc_gen;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        id_valid;
  logic [2:0]  Branch;
  logic [1:0]  Jump;
  logic        Equal;
  logic        rs_sign;
  logic        rs_zero;
  logic [31:0] in_pc;
  logic [31:0] in_branch;
  logic [25:0] in_j;
  logic [31:0] in_jr;
  logic        is_ret;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        pc_bj;
`ifdef PC_GEN_RAS_EN
  logic        ras_empty;
  logic        ras_full;
`endif

  pc_gen #(
    .XLEN     (32),
    .RESET_PC (RPC),
    .RAS_DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (stall),
    .id_valid (id_valid),
    .Branch   (Branch),
    .Jump     (Jump),
    .Equal    (Equal),
    .rs_sign  (rs_sign),
    .rs_zero  (rs_zero),
    .in_pc    (in_pc),
    .in_branch(in_branch),
    .in_j     (in_j),
    .in_jr    (in_jr),
    .is_ret   (is_ret),
    .pc       (pc),
    .next_pc  (next_pc),
    .pc_bj    (pc_bj)
`ifdef PC_GEN_RAS_EN
    ,
    .ras_empty(ras_empty),
    .ras_full (ras_full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        valid;
    logic [2:0]  br;
    logic [1:0]  jmp;
    logic        eq;
    logic        sgn;
    logic        zro;
    logic        ret;
    logic [31:0] ipc;
    logic [31:0] ibr;
    logic [25:0] ij;
    logic [31:0] ijr;
  } stim_t;

  // kind: 0 = redirect to tgt, 1 = sequential (pc+1), 2 = hold pc
  typedef struct {
    stim_t       s;
    logic        bj;
    int          kind;
    logic [31:0] tgt;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  vec_t        vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.stall = 1'b0; s.valid = 1'b0; s.br = 3'b000; s.jmp = 2'b00;
    s.eq = 1'b0; s.sgn = 1'b0; s.zro = 1'b0; s.ret = 1'b0;
    s.ipc = '0; s.ibr = '0; s.ij = '0; s.ijr = '0;
    return s;
  endfunction

  function automatic stim_t br_op(input logic [2:0] op, input logic eq, input logic sgn,
                                  input logic zro, input logic [31:0] ipc, input logic [31:0] ibr);
    stim_t s = idle();
    s.valid = 1'b1; s.br = op; s.eq = eq; s.sgn = sgn; s.zro = zro;
    s.ipc = ipc; s.ibr = ibr;
    return s;
  endfunction

  task automatic add_vec(input stim_t s, input logic bj, input int kind, input logic [31:0] tgt);
    vec_t v;
    v.s = s; v.bj = bj; v.kind = kind; v.tgt = tgt;
    vecs.push_back(v);
  endtask

  task automatic drive(input stim_t s);
    stall = s.stall; id_valid = s.valid; Branch = s.br; Jump = s.jmp;
    Equal = s.eq; rs_sign = s.sgn; rs_zero = s.zro; is_ret = s.ret;
    in_pc = s.ipc; in_branch = s.ibr; in_j = s.ij; in_jr = s.ijr;
  endtask

  // Behavioural model: what the fetch unit should do for one decode slot.
  function automatic void model_eval(input stim_t s, output logic bj, output logic [31:0] nxt);
    bit act = s.valid && !s.stall;
    bit cond;
    case (s.br)
      3'd1: cond = s.eq;
      3'd2: cond = !s.eq;
      3'd3: cond = s.sgn || s.zro;
      3'd4: cond = !s.sgn && !s.zro;
      3'd5: cond = s.sgn;
      3'd6: cond = !s.sgn;
      default: cond = 0;
    endcase
    bj = act && (s.jmp != 0 || cond);
    if (s.stall) nxt = m_pc;
    else if (act && s.jmp == 2'd1) begin
      nxt = s.ijr;
`ifdef PC_GEN_RAS_EN
      if (s.ret && m_ras.size() > 0) nxt = m_ras[m_ras.size()-1];
`endif
    end
    else if (act && s.jmp != 0) nxt = {s.ipc[31:26], s.ij};
    else if (bj) nxt = s.ipc + s.ibr + 32'd1;
    else nxt = m_pc + 32'd1;
  endfunction

  function automatic void model_commit(input stim_t s);
`ifdef PC_GEN_RAS_EN
    bit act = s.valid && !s.stall;
    if (act && s.jmp == 2'd2) begin
      m_ras.push_back(s.ipc + 32'd1);
      if (m_ras.size() > 4) void'(m_ras.pop_front());
    end else if (act && s.jmp == 2'd1 && s.ret && m_ras.size() > 0) begin
      void'(m_ras.pop_back());
    end
`else
    if (s.valid) return;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    drive(idle());
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    m_pc = RPC;
    m_ras.delete();
  endtask

  initial begin
    stim_t       s;
    logic        ebj;
    logic [31:0] enxt;

    rst_n = 1'b1;
    drive(idle());
    #1;
    reset_dut();

    // Reset state and sequential fetch out of reset.
    chk("rst_pc", pc, RPC);
    chk("rst_bj", {31'd0, pc_bj}, 32'd0);
`ifdef PC_GEN_RAS_EN
    chk("rst_ras_empty", {31'd0, ras_empty}, 32'd1);
    chk("rst_ras_full", {31'd0, ras_full}, 32'd0);
`endif
    step();
    chk("seq_pc1", pc, RPC + 32'd1);
    step();
    chk("seq_pc2", pc, RPC + 32'd2);
    chk("seq_bj", {31'd0, pc_bj}, 32'd0);
    m_pc = RPC + 32'd2;

    // Directed vector table.
    add_vec(idle(), 1'b0, 1, '0);
    add_vec(br_op(3'd1, 1, 0, 0, 32'h20, 32'hFFFF_FFFC), 1'b1, 0, 32'h1D);
    add_vec(br_op(3'd1, 0, 0, 0, 32'h20, 32'hFFFF_FFFC), 1'b0, 1, '0);
    s = br_op(3'd1, 1, 0, 0, 32'hFC00_0010, 32'h4);
    s.jmp = 2'b11; s.ij = 26'h40;
    add_vec(s, 1'b1, 0, 32'hFC00_0040);
    s.stall = 1'b1;
    add_vec(s, 1'b0, 2, '0);
    add_vec(br_op(3'd5, 0, 1, 0, 32'h200, 32'h5), 1'b1, 0, 32'h206);
    add_vec(br_op(3'd6, 0, 1, 0, 32'h200, 32'h5), 1'b0, 1, '0);
    add_vec(br_op(3'd2, 0, 0, 0, 32'h300, 32'h10), 1'b1, 0, 32'h311);
    add_vec(br_op(3'd3, 0, 0, 1, 32'h400, 32'h2), 1'b1, 0, 32'h403);
    add_vec(br_op(3'd4, 0, 0, 0, 32'h500, 32'h7), 1'b1, 0, 32'h508);
    add_vec(br_op(3'd4, 0, 0, 1, 32'h500, 32'h7), 1'b0, 1, '0);
    add_vec(br_op(3'd7, 1, 1, 1, 32'h600, 32'h7), 1'b0, 1, '0);
    s = idle(); s.jmp = 2'b11; s.ipc = 32'hFC00_0010; s.ij = 26'h40;
    add_vec(s, 1'b0, 1, '0);
    s = idle(); s.valid = 1'b1; s.jmp = 2'b10; s.ipc = 32'h0800_0005; s.ij = 26'h3;
    add_vec(s, 1'b1, 0, 32'h0800_0003);
    s = idle(); s.valid = 1'b1; s.jmp = 2'b01; s.ijr = 32'hFFFF_FFFF;
    add_vec(s, 1'b1, 0, 32'hFFFF_FFFF);
    add_vec(idle(), 1'b0, 1, '0);

    foreach (vecs[i]) begin
      case (vecs[i].kind)
        0:       enxt = vecs[i].tgt;
        1:       enxt = m_pc + 32'd1;
        default: enxt = m_pc;
      endcase
      drive(vecs[i].s);
      #1;
      chk($sformatf("vec%0d_bj", i), {31'd0, pc_bj}, {31'd0, vecs[i].bj});
      chk($sformatf("vec%0d_next", i), next_pc, enxt);
      model_commit(vecs[i].s);
      step();
      chk($sformatf("vec%0d_pc", i), pc, enxt);
      m_pc = enxt;
    end
    chk("wrap_pc", pc, 32'h0);

    // Asynchronous reset between edges while a jump is pending.
    s = idle(); s.valid = 1'b1; s.jmp = 2'b11; s.ipc = 32'hFC00_0010; s.ij = 26'h40;
    drive(s);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pc", pc, RPC);
    drive(idle());
    step();
    chk("rst_hold_pc", pc, RPC);
    rst_n = 1'b1;
    #1;
    chk("rst_release_pc", pc, RPC);
    step();
    chk("rst_first_seq", pc, RPC + 32'd1);
    m_pc = RPC + 32'd1;
    m_ras.delete();

    // Randomized stimulus against the model.
    for (int n = 0; n < 400; n++) begin
      s.stall = ($urandom_range(0, 4) == 0);
      s.valid = ($urandom_range(0, 3) != 0);
      s.br    = 3'($urandom);
      s.jmp   = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      s.eq    = 1'($urandom);
      s.sgn   = 1'($urandom);
      s.zro   = 1'($urandom);
      s.ret   = 1'($urandom);
      s.ipc   = $urandom;
      s.ibr   = $urandom;
      s.ij    = 26'($urandom);
      s.ijr   = $urandom;
      model_eval(s, ebj, enxt);
      drive(s);
      #1;
      chk($sformatf("rnd%0d_bj", n), {31'd0, pc_bj}, {31'd0, ebj});
      chk($sformatf("rnd%0d_next", n), next_pc, enxt);
      model_commit(s);
      step();
      chk($sformatf("rnd%0d_pc", n), pc, enxt);
      m_pc = enxt;
    end

`ifdef PC_GEN_RAS_EN
    // Return-address stack: overflow overwrites the oldest, underflow uses in_jr.
    begin
      logic [31:0] exp_ret[5];
      exp_ret[0] = 32'h51; exp_ret[1] = 32'h41; exp_ret[2] = 32'h31;
      exp_ret[3] = 32'h21; exp_ret[4] = 32'hDEAD;
      reset_dut();
      for (int k = 1; k <= 5; k++) begin
        s = idle(); s.valid = 1'b1; s.jmp = 2'b10; s.ipc = 32'(k * 16); s.ij = 26'h77;
        drive(s);
        #1;
        chk($sformatf("jal%0d_next", k), next_pc, {s.ipc[31:26], s.ij});
        model_commit(s);
        step();
      end
      chk("ras_full", {31'd0, ras_full}, 32'd1);
      for (int k = 0; k < 5; k++) begin
        s = idle(); s.valid = 1'b1; s.jmp = 2'b01; s.ret = 1'b1; s.ijr = 32'hDEAD;
        drive(s);
        #1;
        chk($sformatf("ret%0d_next", k), next_pc, exp_ret[k]);
        model_commit(s);
        step();
        chk($sformatf("ret%0d_pc", k), pc, exp_ret[k]);
      end
      chk("ras_empty", {31'd0, ras_empty}, 32'd1);
    end
`endif

    drive(idle());
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
